// File: rtl/i281_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i281_pkg
// Brief    : Shared i281 code-memory constants and code-loader state type.
// Revision : 1.0
// ============================================================================
package i281_pkg;

  localparam int I281_CODE_DEPTH = 16;
  localparam int I281_INSTR_W    = 16;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    LOAD_HI = 2'd2,
    LOAD_LO = 2'd3
  } code_ld_state_t;

endpackage
`default_nettype wire

// File: rtl/i281_code_bank.sv
`default_nettype none
// ============================================================================
// Module   : i281_code_bank
// Brief    : DEPTH x WIDTH register array, async clear, one write port,
//            combinational read port.
// Revision : 1.0
// ============================================================================
module i281_code_bank
  import i281_pkg::*;
#(
  parameter int DEPTH  = I281_CODE_DEPTH,
  parameter int WIDTH  = I281_INSTR_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // No write bypass: a written word becomes visible the cycle after its edge.
  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/i281_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : i281_code_loader
// Brief    : Upper-half i281 instruction bank; copies power-on words after
//            reset and accepts byte-serial reloads from the host.
// Revision : 1.0
// ============================================================================
module i281_code_loader
  import i281_pkg::*;
#(
  parameter int DEPTH  = I281_CODE_DEPTH,
  parameter int WIDTH  = I281_INSTR_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   b0I,
  input  logic [WIDTH-1:0]   b1I,
  input  logic [WIDTH-1:0]   b2I,
  input  logic [WIDTH-1:0]   b3I,
  input  logic [WIDTH-1:0]   b4I,
  input  logic [WIDTH-1:0]   b5I,
  input  logic [WIDTH-1:0]   b6I,
  input  logic [WIDTH-1:0]   b7I,
  input  logic [WIDTH-1:0]   b8I,
  input  logic [WIDTH-1:0]   b9I,
  input  logic [WIDTH-1:0]   b10I,
  input  logic [WIDTH-1:0]   b11I,
  input  logic [WIDTH-1:0]   b12I,
  input  logic [WIDTH-1:0]   b13I,
  input  logic [WIDTH-1:0]   b14I,
  input  logic [WIDTH-1:0]   b15I,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [WIDTH/2-1:0] ld_byte,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic               ld_done,
  output logic [ADDR_W:0]    ld_count
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_full = (ADDR_W + 1)'(DEPTH);

  code_ld_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W:0]     r_count;
  logic [WIDTH/2-1:0]  r_hi;
  logic                r_done;

  logic                w_we;
  logic [WIDTH-1:0]    w_wdata;
  logic                w_adv;
  logic                w_clr;
  logic                w_hi_ld;
  logic                w_done_nxt;
  logic [WIDTH-1:0]    w_binit [DEPTH];

  assign w_binit[0]  = b0I;
  assign w_binit[1]  = b1I;
  assign w_binit[2]  = b2I;
  assign w_binit[3]  = b3I;
  assign w_binit[4]  = b4I;
  assign w_binit[5]  = b5I;
  assign w_binit[6]  = b6I;
  assign w_binit[7]  = b7I;
  assign w_binit[8]  = b8I;
  assign w_binit[9]  = b9I;
  assign w_binit[10] = b10I;
  assign w_binit[11] = b11I;
  assign w_binit[12] = b12I;
  assign w_binit[13] = b13I;
  assign w_binit[14] = b14I;
  assign w_binit[15] = b15I;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wdata     = w_binit[r_idx];
    w_adv       = 1'b0;
    w_clr       = 1'b0;
    w_hi_ld     = 1'b0;
    w_done_nxt  = 1'b0;
    ld_busy     = 1'b1;
    ld_ready    = 1'b0;
    case (r_state)
      INIT: begin
        w_we  = 1'b1;
        w_adv = 1'b1;
        if (r_idx == c_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      IDLE: begin
        ld_busy = 1'b0;
        if (ld_start) begin
          w_clr       = 1'b1;
          w_state_nxt = LOAD_HI;
        end
      end
      LOAD_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          w_hi_ld     = 1'b1;
          w_state_nxt = LOAD_LO;
        end
      end
      LOAD_LO: begin
        ld_ready = 1'b1;
        w_wdata  = {r_hi, ld_byte};
        if (ld_valid) begin
          w_we  = 1'b1;
          w_adv = 1'b1;
          if (r_idx == c_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = LOAD_HI;
          end
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // idx wraps 15->0 only on the same edge that leaves for IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_hi_ld) begin
        r_hi <= ld_byte;
      end
      if (w_clr) begin
        r_idx   <= '0;
        r_count <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 1'b1;
        if (r_count != c_full) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign ld_done  = r_done;
  assign ld_count = r_count;

  i281_code_bank #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (r_idx),
    .wdata (w_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_i281_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_i281_code_loader
// Brief    : Directed self-checking bench for i281_code_loader.
// Revision : 1.0
// ============================================================================
module tb_i281_code_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] b [16];
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic [4:0]  ld_count;

  int errors = 0;
  int checks = 0;
  int notready = 0;
  int gap_bad = 0;

  always #5 clk = ~clk;

  i281_code_loader dut (
    .clk(clk), .rst(rst),
    .b0I(b[0]),   .b1I(b[1]),   .b2I(b[2]),   .b3I(b[3]),
    .b4I(b[4]),   .b5I(b[5]),   .b6I(b[6]),   .b7I(b[7]),
    .b8I(b[8]),   .b9I(b[9]),   .b10I(b[10]), .b11I(b[11]),
    .b12I(b[12]), .b13I(b[13]), .b14I(b[14]), .b15I(b[15]),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_count(ld_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  // Gapped bytes idle with junk on ld_byte; ld_count must not move meanwhile.
  task automatic send_byte(input logic [7:0] v, input bit gapped);
    logic [4:0] held;
    if (gapped) begin
      held = ld_count;
      repeat ($urandom_range(0, 3)) begin
        ld_valid = 1'b0;
        ld_byte  = 8'hFF;
        tick();
        if (ld_count !== held || ld_ready !== 1'b1) gap_bad++;
      end
    end
    ld_valid = 1'b1;
    ld_byte  = v;
    if (ld_ready !== 1'b1) notready++;
    tick();
  endtask

  task automatic send_word(input logic [15:0] w, input bit gapped);
    send_byte(w[15:8], gapped);
    send_byte(w[7:0], gapped);
  endtask

  // Returns the number of busy cycles seen after reset release (bounded).
  task automatic wait_init(output int cycles, output int early_done);
    cycles = 0;
    early_done = 0;
    while (ld_busy === 1'b1 && cycles < 40) begin
      if (ld_done === 1'b1) early_done++;
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset_init();
    int cyc, ed;
    rst = 1'b1;
    rd_addr = 4'd0;
    tick();
    tick();
    checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", ld_busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ld_done); end
    checks++; if (ld_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ld_count); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    rst = 1'b0;
    wait_init(cyc, ed);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL init_busy_cycles got=%0d exp=16", cyc); end
    checks++; if (ed !== 0) begin errors++; $display("FAIL init_early_done got=%0d exp=0", ed); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b exp=1", ld_done); end
    checks++; if (ld_count !== 5'd16) begin errors++; $display("FAIL init_count got=%0d exp=16", ld_count); end
    tick();
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL init_done_pulse got=%b exp=0", ld_done); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== b[i]) begin errors++; $display("FAIL init_word%0d got=%h exp=%h", i, rd_data, b[i]); end
    end
  endtask

  task automatic test_reload();
    notready = 0;
    start_load();
    checks++; if (ld_ready !== 1'b1 || ld_count !== 5'd0) begin errors++; $display("FAIL reload_start ready=%b count=%0d exp 1/0", ld_ready, ld_count); end
    for (int i = 0; i < 16; i++) send_word(16'hA500 + 16'(i), 1'b0);
    ld_valid = 1'b0;
    checks++; if (notready !== 0) begin errors++; $display("FAIL reload_ready_gaps got=%0d exp=0", notready); end
    checks++; if (ld_count !== 5'd16) begin errors++; $display("FAIL reload_count got=%0d exp=16", ld_count); end
    checks++; if (ld_done !== 1'b1 || ld_busy !== 1'b0) begin errors++; $display("FAIL reload_done done=%b busy=%b exp 1/0", ld_done, ld_busy); end
    rd_addr = 4'd9;
    #1;
    checks++; if (rd_data !== 16'hA509) begin errors++; $display("FAIL reload_word9 got=%h exp=A509", rd_data); end
    tick();
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reload_done_pulse got=%b exp=0", ld_done); end
  endtask

  task automatic test_start_while_busy();
    int cyc, ed;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_start = 1'b1;
    repeat (10) tick();
    ld_start = 1'b0;
    wait_init(cyc, ed);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL init_start_ignored remaining_busy=%0d exp=6", cyc); end
    tick();
    tick();
    checks++; if (ld_ready !== 1'b0 || ld_busy !== 1'b0) begin errors++; $display("FAIL init_start_queued ready=%b busy=%b exp 0/0", ld_ready, ld_busy); end
    start_load();
    for (int i = 0; i < 16; i++) begin
      if (i == 7) ld_start = 1'b1;
      send_word(16'h3C00 + 16'(i), 1'b0);
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
    checks++; if (ld_count !== 5'd16 || ld_done !== 1'b1) begin errors++; $display("FAIL busy_start_count count=%0d done=%b exp 16/1", ld_count, ld_done); end
    rd_addr = 4'd15;
    #1;
    checks++; if (rd_data !== 16'h3C0F) begin errors++; $display("FAIL busy_start_word15 got=%h exp=3C0F", rd_data); end
    tick();
    checks++; if (ld_ready !== 1'b0 || ld_busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart ready=%b busy=%b exp 0/0", ld_ready, ld_busy); end
  endtask

  task automatic test_gapped();
    gap_bad = 0;
    notready = 0;
    start_load();
    for (int i = 0; i < 16; i++) send_word(16'hA500 + 16'(i), 1'b1);
    ld_valid = 1'b0;
    checks++; if (gap_bad !== 0 || notready !== 0) begin errors++; $display("FAIL gapped_stall gap_bad=%0d notready=%0d exp 0/0", gap_bad, notready); end
    checks++; if (ld_count !== 5'd16 || ld_done !== 1'b1) begin errors++; $display("FAIL gapped_end count=%0d done=%b exp 16/1", ld_count, ld_done); end
    for (int i = 0; i < 16; i += 5) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 16'hA500 + 16'(i)) begin errors++; $display("FAIL gapped_word%0d got=%h exp=%h", i, rd_data, 16'hA500 + 16'(i)); end
    end
    tick();
  endtask

  task automatic test_write_latency();
    start_load();
    for (int i = 0; i < 4; i++) send_word(16'h7700 + 16'(i), 1'b0);
    rd_addr = 4'd4;
    send_byte(8'h77, 1'b0);
    ld_valid = 1'b1;
    ld_byte  = 8'h04;
    #1;
    checks++; if (rd_data !== 16'hA504) begin errors++; $display("FAIL latency_old got=%h exp=A504", rd_data); end
    tick();
    checks++; if (rd_data !== 16'h7704) begin errors++; $display("FAIL latency_new got=%h exp=7704", rd_data); end
    for (int i = 5; i < 16; i++) send_word(16'h7700 + 16'(i), 1'b0);
    ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc, ed;
    start_load();
    for (int i = 0; i < 6; i++) send_word(16'h5A00 + 16'(i), 1'b0);
    ld_valid = 1'b0;
    rd_addr = 4'd5;
    #1;
    checks++; if (rd_data !== 16'h5A05) begin errors++; $display("FAIL mid_before got=%h exp=5A05", rd_data); end
    rst = 1'b1;
    #1;
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_data got=%h exp=0000", rd_data); end
    checks++; if (ld_busy !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 5'd0) begin errors++; $display("FAIL mid_reset_ctl busy=%b ready=%b count=%0d exp 1/0/0", ld_busy, ld_ready, ld_count); end
    tick();
    rst = 1'b0;
    wait_init(cyc, ed);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL mid_init_cycles got=%0d exp=16", cyc); end
    for (int i = 0; i < 6; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== b[i]) begin errors++; $display("FAIL mid_word%0d got=%h exp=%h", i, rd_data, b[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte = '0;
    for (int i = 0; i < 16; i++) b[i] = 16'h0000;
    b[0] = 16'hE0F4;
    b[1] = 16'h5001;
    b[2] = 16'hE0EE;
    test_reset_init();
    test_reload();
    test_start_while_busy();
    test_gapped();
    test_write_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
